// File: rtl/mux_pkg.sv
// Shared constants for the 8:1 round-robin merge.
// Also fixes how out_sel bits map onto the downstream 1:8 demux enables.
package mux_pkg;

  localparam int NCH   = 8;
  localparam int SELW  = 3;
  localparam int W_DEF = 8;

  // out_sel bit feeding each demux enable (e1 is the MSB)
  localparam int DMX_E1_BIT = 2;
  localparam int DMX_E2_BIT = 1;
  localparam int DMX_E3_BIT = 0;

  function automatic logic [SELW-1:0] next_ptr(
    input logic [SELW-1:0] g
  );
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter: rotate, lowest-bit pick, rotate back.
// Outputs are gated by en so nothing is granted while the sink is busy.
module rr_arb8
  import mux_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [2*NCH-1:0] w_rdbl;
  logic [2*NCH-1:0] w_gdbl;
  logic [NCH-1:0]   w_rot;
  logic [NCH-1:0]   w_pick;
  logic [SELW-1:0]  w_pidx;

  always_comb begin
    w_rdbl = {req, req} >> ptr;
    w_rot  = w_rdbl[NCH-1:0];
    w_pick = w_rot & (~w_rot + 1'b1);
    w_pidx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_pick[i]) w_pidx = SELW'(i);
    end
    w_gdbl = {w_pick, w_pick} << ptr;
    any    = en & (|req);
    gnt    = any ? w_gdbl[2*NCH-1:NCH] : '0;
    idx    = w_pidx + ptr;
  end

endmodule

// File: rtl/mux81_rr.sv
// 8:1 round-robin merge onto one registered valid/ready stream.
// Each word is tagged with its source channel in out_sel.
module mux81_rr
  import mux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic [SELW-1:0] r_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_sel;

  logic            w_load;
  logic            w_en;
  logic [NCH-1:0]  w_gnt;
  logic [SELW-1:0] w_idx;
  logic            w_any;
  logic [W-1:0]    w_data;

  assign w_load = ~r_out_valid | out_ready;
  // Keep every in_ready low while reset is held.
  assign w_en   = w_load & rst_n;

  rr_arb8 u_arb (
    .req (in_valid),
    .ptr (r_ptr),
    .en  (w_en),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_data = in_data[w_idx*W +: W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_idx;
        r_ptr       <= next_ptr(w_idx);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux81_rr.sv
// Directed bench for mux81_rr with a queue scoreboard.
// Also models the downstream 1:8 demux for the round-trip step.
module tb_mux81_rr;
  import mux_pkg::*;

  localparam int WD = 8;

  typedef struct packed {
    logic [2:0]    sel;
    logic [WD-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_valid;
  logic [8*WD-1:0]   in_data;
  logic [7:0]        in_ready;
  logic              out_valid;
  logic [WD-1:0]     out_data;
  logic [2:0]        out_sel;
  logic              out_ready;
  logic [7:0]        r_dmx;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux81_rr #(.W(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always_comb begin
    r_dmx = '0;
    if (out_valid && out_data[0])
      r_dmx[{out_sel[DMX_E1_BIT],
             out_sel[DMX_E2_BIT],
             out_sel[DMX_E3_BIT]}] = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int d);
    exp_t e;
    e.sel  = 3'(s);
    e.data = WD'(d);
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_sel", 32'(out_sel), 32'(e.sel));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 8; i++)
      in_data[i*WD +: WD] = WD'(8'hA0 + i);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    set_data();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_sel", 32'(out_sel), 0);
    end
  endtask

  initial begin
    int ptr_exp[4];
    ptr_exp = '{2, 7, 2, 7};

    // Reset, then full load
    do_reset();
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(in_ready), 32'h01);
    for (int i = 0; i < 9; i++) push(i % 8, 8'hA0 + (i % 8));
    repeat (9) cyc();
    in_valid = 8'h00;
    cyc();
    cyc();
    chk("full_drained", 32'(sb.size()), 0);
    chk("full_idle", 32'(out_valid), 0);

    // Wrap and skip: channels 1 and 6
    do_reset();
    in_valid = 8'h42;
    rst_n = 1'b1;
    #1;
    chk("skip_first", 32'(in_ready), 32'h02);
    push(1, 8'hA1);
    push(6, 8'hA6);
    push(1, 8'hA1);
    push(6, 8'hA6);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("skip_ptr", 32'(dut.r_ptr), 32'(ptr_exp[k]));
    end
    in_valid = 8'h00;
    cyc();
    cyc();
    chk("skip_drained", 32'(sb.size()), 0);

    // Backpressure with (3,0x33) held
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h08;
    in_data[3*WD +: WD] = 8'h33;
    rst_n = 1'b1;
    push(3, 8'h33);
    cyc();
    in_valid = 8'h20;
    in_data[5*WD +: WD] = 8'h55;
    push(5, 8'h55);
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_sel", 32'(out_sel), 3);
      chk("bp_data", 32'(out_data), 32'h33);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(in_ready), 32'h20);
    cyc();
    in_valid = 8'h00;
    chk("bp_next_sel", 32'(out_sel), 5);
    chk("bp_next_data", 32'(out_data), 32'h55);
    cyc();
    cyc();
    chk("bp_drained", 32'(sb.size()), 0);
    chk("bp_idle", 32'(out_valid), 0);

    // Round trip through the 1:8 demux
    do_reset();
    in_valid = 8'h20;
    in_data[5*WD +: WD] = 8'h01;
    rst_n = 1'b1;
    #1;
    chk("rt_before", 32'(r_dmx), 0);
    push(5, 1);
    cyc();
    in_valid = 8'h00;
    chk("rt_r6", 32'(r_dmx), 32'h20);
    cyc();
    chk("rt_after", 32'(r_dmx), 0);

    // Reset while stalled with a held word
    do_reset();
    in_valid = 8'h04;
    out_ready = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("ms_valid", 32'(out_valid), 1);
    chk("ms_sel", 32'(out_sel), 2);
    rst_n = 1'b0;
    in_valid = 8'hFF;
    #1;
    chk("ms_rst_ready", 32'(in_ready), 0);
    cyc();
    chk("ms_valid_clr", 32'(out_valid), 0);
    chk("ms_ptr", 32'(dut.r_ptr), 0);
    chk("ms_rst_ready2", 32'(in_ready), 0);
    cyc();
    chk("ms_rst_ready3", 32'(in_ready), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ms_first_grant", 32'(in_ready), 32'h01);
    in_valid = 8'h00;
    cyc();
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux81_rr.md
# mux81_rr

8-to-1 round-robin merge with valid/ready handshakes: collects words from eight producer channels onto one registered output stream, tagging each word with its 3-bit source index. It is the collecting end of the 1:8 demux path. `out_sel` is encoded so that a downstream 1:8 demux driven with `e1=out_sel[2]`, `e2=out_sel[1]`, `e3=out_sel[0]` routes the word back to the same-numbered output `r(i+1)`. Sits between eight independent sources and a single shared consumer.

## Interface
- `W`, default 8: data width per channel.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  8  channel i has a word pending.
- `in_data`  in  8*W  channel i data at bits `[i*W +: W]`.
- `in_ready`  out  8  one-hot or zero; word on channel i accepted this cycle when `in_valid[i] & in_ready[i]`.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  registered word.
- `out_sel`  out  3  source channel index 0..7 of `out_data`.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.

## Operation
- State:
  - `ptr[2:0]`: highest-priority channel.
  - Output register: `out_valid`, `out_data`, `out_sel`.
- `load = ~out_valid | out_ready`. The register can take a new word this cycle.
- Grant: when `load`, the first channel i with `in_valid[i]`, searching `ptr, ptr+1, …, ptr+7` mod 8, gets `in_ready[i]=1`. All other `in_ready` bits are 0. With `load=0`, all `in_ready` are 0.
- `in_ready` is combinational from `in_valid`, `ptr`, `out_valid`, `out_ready`. Sources must not make `in_valid` depend on `in_ready`.
- On accept of channel g:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= g+1` mod 8 (wrap 7→0).
- On `load` with no valid input: `out_valid <= 0` if draining. `out_data`/`out_sel` hold. `ptr` holds.
- Stall (`out_valid & ~out_ready`): output register and `ptr` hold, all `in_ready` are 0.
- Simultaneous drain and accept in one cycle is permitted; there is no bubble.
- Source obligation: a source holding `in_valid` must keep `in_data` stable until accepted. The block never drops or duplicates a word.

## Timing
- Reset (`rst_n=0` at edge): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. `in_ready` is 0 during reset cycles.
- Reset mid-transfer discards the held word. The first grant after reset goes to the lowest index ≥0 with valid.
- Latency: word accepted at edge N appears on `out_*` after edge N; earliest consumer acceptance at edge N+1.
- Throughput: 1 word/cycle with `out_ready` held high.
- Fairness: with all 8 channels continuously valid, grant order is 0,1,…,7,0,… Any continuously valid channel waits at most 7 accepts.

## Structure
- Shared package `mux_pkg`:
  - `NCH=8`, `SELW=3`.
  - Default `W`.
  - Sel-to-demux-enable mapping documented as constants.
- Sub-module `rr_arb8`:
  - Inputs: `req[7:0]`, `ptr[2:0]`, `en`.
  - Outputs: `gnt[7:0]` (one-hot), `idx[2:0]`, `any`.
  - Implemented as a rotate / priority-pick / rotate-back.
- Top level holds the output register, `ptr`, and the data mux `in_data[idx]`.

## Test plan
- Reset:
  - Stimulus: `rst_n=0` for 2 cycles, all channels valid.
  - Required: `in_ready=0`, `out_valid=0`, `out_sel=0`. First accept after release is channel 0.
- Full load, `W=8`:
  - Stimulus: channel i presents `0xA0+i` continuously, `out_ready=1`.
  - Required: outputs `(sel,data)` = (0,A0),(1,A1)…(7,A7),(0,A0) on consecutive cycles.
- Wrap and skip:
  - Stimulus: only channels 6 and 1 valid, `ptr=0` after reset.
  - Required: grants 1, 6, 1, 6…; `ptr` goes 2 → 7 → 2.
- Backpressure:
  - Stimulus: `out_ready=0` for 4 cycles with word (3,0x33) held.
  - Required: `out_*` stable, `in_ready=0`.
  - On release: 0x33 is consumed and the next grant loads in the same cycle.
- Round trip:
  - Stimulus: feed `out_sel` and `out_data` into the 1:8 demux (`e1..e3 = sel[2:0]`), channel 5 sending 1.
  - Required: only `r6` high, exactly one cycle after acceptance.
- Reset mid-stall:
  - Stimulus: assert `rst_n=0` while `out_valid=1`, `out_ready=0`.
  - Required: next cycle `out_valid=0`, `ptr=0`, and no `in_ready` bit asserts during reset.
